// File: rtl/bank_readback_ctrl.sv
// Small circular FIFO used to buffer tagged read words ahead of the output stream.
// Latency: a pushed word is visible at the head the next cycle; the writer must never push when full.
module bank_readback_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_wr_vld,
   input  logic [W-1:0]           i_wr_dat,
   output logic                   o_rd_vld,
   output logic [W-1:0]           o_rd_dat,
   input  logic                   i_rd_rdy,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [PW:0]   r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign w_wr     = i_wr_vld && (r_cnt != (PW+1)'(DEPTH));
   assign w_rd     = i_rd_rdy && o_rd_vld;
   assign o_rd_vld = (r_cnt != '0);
   assign o_rd_dat = r_mem[r_rp];
   assign o_count  = r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + PW'(1);
         if (w_rd) r_rp <= r_rp + PW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= i_wr_dat;
   end
endmodule

// Walks the enabled banks in ascending order over addresses 0..iLen-1 and streams each word with its tag.
// First oValid RD_LAT+2 cycles after iStart; reads stop at 4 outstanding words so any iReady pattern is lossless.
module bank_readback_ctrl #(
   parameter int NUM_BANK = 16,
   parameter int AW       = 9,
   parameter int DW       = 128,
   parameter int RD_LAT   = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iStart,
   input  logic [NUM_BANK-1:0]    iBankMask,
   input  logic [AW:0]            iLen,
   output logic [NUM_BANK-1:0]    o_enb,
   output logic [AW-1:0]          o_addrb,
   input  logic [NUM_BANK*DW-1:0] i_dob,
   output logic                   oValid,
   input  logic                   iReady,
   output logic [DW-1:0]          oData,
   output logic [3:0]             oBank,
   output logic [AW-1:0]          oAddr,
   output logic                   oLast,
   output logic                   oBusy,
   output logic                   oDone
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic          last;
      logic [3:0]    bank;
      logic [AW-1:0] addr;
   } tag_t;

   typedef struct packed {
      tag_t          tag;
      logic [DW-1:0] data;
   } ent_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_BANK-1:0] r_mask;
   logic [AW:0]         r_len;
   logic [3:0]          r_bank;
   logic [AW-1:0]       r_addr;
   logic [2:0]          r_inflight;
   logic [RD_LAT-1:0]   r_tag_vld;
   tag_t                r_tag [RD_LAT];

   logic [AW:0]         w_len_m1;
   logic [3:0]          w_hi_bank;
   logic                w_bank_end;
   logic                w_run_last;
   logic                w_credit;
   logic                w_issue;
   logic                w_accept;
   tag_t                w_issue_tag;
   tag_t                w_end_tag;
   logic                w_end_vld;
   ent_t                w_wr_ent;
   ent_t                w_head;
   logic                w_head_vld;
   logic                w_pop;
   logic [2:0]          w_fifo_cnt;

   function automatic logic [3:0] lowest_bank(input logic [NUM_BANK-1:0] m);
      lowest_bank = '0;
      for (int i = NUM_BANK - 1; i >= 0; i--) begin
         if (m[i]) lowest_bank = 4'(i);
      end
   endfunction

   function automatic logic [3:0] highest_bank(input logic [NUM_BANK-1:0] m);
      highest_bank = '0;
      for (int i = 0; i < NUM_BANK; i++) begin
         if (m[i]) highest_bank = 4'(i);
      end
   endfunction

   function automatic logic [3:0] next_bank(input logic [NUM_BANK-1:0] m, input logic [3:0] b);
      next_bank = b;
      for (int i = NUM_BANK - 1; i >= 0; i--) begin
         if (m[i] && (4'(i) > b)) next_bank = 4'(i);
      end
   endfunction

   assign w_len_m1   = r_len - (AW+1)'(1);
   assign w_hi_bank  = highest_bank(r_mask);
   assign w_bank_end = ({1'b0, r_addr} == w_len_m1);
   assign w_run_last = w_bank_end && (r_bank == w_hi_bank);
   // Outstanding words = reads still in the BRAM/tag pipe plus words already buffered.
   assign w_credit   = ({1'b0, r_inflight} + {1'b0, w_fifo_cnt}) < 4'd4;
   assign w_issue    = (r_state == S_READ) && w_credit;
   assign w_accept   = (r_state == S_IDLE) && iStart;

   assign w_issue_tag.last = w_run_last;
   assign w_issue_tag.bank = r_bank;
   assign w_issue_tag.addr = r_addr;

   always_comb begin
      w_state_nxt = r_state;
      o_enb       = '0;
      if (w_issue) o_enb = NUM_BANK'(1) << r_bank;
      case (r_state)
         S_IDLE:  if (iStart) w_state_nxt = ((|iBankMask) && (|iLen)) ? S_READ : S_DONE;
         S_READ:  if (w_issue && w_run_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_pop && w_head.tag.last && (r_inflight == '0) && (w_fifo_cnt == 3'd1))
                     w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_len   <= '0;
         r_bank  <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_mask <= iBankMask;
            r_len  <= iLen;
            r_bank <= lowest_bank(iBankMask);
            r_addr <= '0;
         end else if (w_issue) begin
            if (w_bank_end) begin
               r_bank <= next_bank(r_mask, r_bank);
               r_addr <= '0;
            end else begin
               r_addr <= r_addr + AW'(1);
            end
         end
      end
   end

   // Tag pipe matches the BRAM read latency so the tag arrives together with i_dob.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag_vld[0] <= w_issue;
         r_tag[0]     <= w_issue_tag;
         for (int i = 1; i < RD_LAT; i++) begin
            r_tag_vld[i] <= r_tag_vld[i-1];
            r_tag[i]     <= r_tag[i-1];
         end
      end
   end

   assign w_end_tag     = r_tag[RD_LAT-1];
   assign w_end_vld     = r_tag_vld[RD_LAT-1];
   assign w_wr_ent.tag  = w_end_tag;
   assign w_wr_ent.data = i_dob[w_end_tag.bank*DW +: DW];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
      end else begin
         case ({w_issue, w_end_vld})
            2'b10:   r_inflight <= r_inflight + 3'd1;
            2'b01:   r_inflight <= r_inflight - 3'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   bank_readback_fifo #(
      .W     ($bits(ent_t)),
      .DEPTH (4)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_wr_vld (w_end_vld),
      .i_wr_dat (w_wr_ent),
      .o_rd_vld (w_head_vld),
      .o_rd_dat (w_head),
      .i_rd_rdy (iReady),
      .o_count  (w_fifo_cnt)
   );

   assign w_pop   = w_head_vld && iReady;
   assign oValid  = w_head_vld;
   assign oData   = w_head_vld ? w_head.data     : '0;
   assign oBank   = w_head_vld ? w_head.tag.bank : '0;
   assign oAddr   = w_head_vld ? w_head.tag.addr : '0;
   assign oLast   = w_head_vld && w_head.tag.last;
   assign o_addrb = r_addr;
   assign oBusy   = (r_state != S_IDLE);
   assign oDone   = (r_state == S_DONE);
endmodule

// File: tb/tb_bank_readback_ctrl.sv
// Drives RD_LAT=1 and RD_LAT=2 instances in lockstep against a behavioural BRAM and checks each scenario directly.
module tb_bank_readback_ctrl;
   int tests = 0;
   int fails = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        rdy = 1'b0;
   logic [15:0] mask = '0;
   logic [9:0]  len = '0;

   logic [15:0]   enb   [2];
   logic [8:0]    addrb [2];
   logic          vld   [2];
   logic [127:0]  dat   [2];
   logic [3:0]    bnk   [2];
   logic [8:0]    adr   [2];
   logic          lst   [2];
   logic          busy  [2];
   logic          done  [2];
   logic [2047:0] dob0;
   logic [2047:0] dob1;

   logic [127:0] mem [16][512];
   logic [127:0] s1  [2][16];
   logic [127:0] s2  [16];

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++)
         for (int b = 0; b < 16; b++)
            if (enb[d][b]) s1[d][b] <= mem[b][addrb[d]];
      for (int b = 0; b < 16; b++) s2[b] <= s1[1][b];
   end

   always_comb begin
      dob0 = '0;
      dob1 = '0;
      for (int b = 0; b < 16; b++) begin
         dob0[b*128 +: 128] = s1[0][b];
         dob1[b*128 +: 128] = s2[b];
      end
   end

   bank_readback_ctrl #(.RD_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .iStart(start), .iBankMask(mask), .iLen(len),
      .o_enb(enb[0]), .o_addrb(addrb[0]), .i_dob(dob0), .oValid(vld[0]), .iReady(rdy),
      .oData(dat[0]), .oBank(bnk[0]), .oAddr(adr[0]), .oLast(lst[0]), .oBusy(busy[0]), .oDone(done[0]));

   bank_readback_ctrl #(.RD_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .iStart(start), .iBankMask(mask), .iLen(len),
      .o_enb(enb[1]), .o_addrb(addrb[1]), .i_dob(dob1), .oValid(vld[1]), .iReady(rdy),
      .oData(dat[1]), .oBank(bnk[1]), .oAddr(adr[1]), .oLast(lst[1]), .oBusy(busy[1]), .oDone(done[1]));

   // Per-run observations for each instance
   logic [3:0]   wb [2][256];
   logic [8:0]   wa [2][256];
   logic [127:0] wd [2][256];
   logic         wl [2][256];
   int nw[2], nlast[2], first_enb[2], last_enb[2], enb_cnt[2], first_vld[2], last_vld[2];
   int vld_cnt[2], done_t[2], busy_low_t[2], hold_err[2], max_out[2], onehot_err[2], accepted[2];

   function automatic logic [127:0] pat(input int n);
      logic [3:0]   n4;
      logic [127:0] p;
      n4 = 4'(n);
      p  = '0;
      p[31:0] = {4'h4, n4, 4'h3, n4, 4'h2, n4, 4'h1, n4};
      return p;
   endfunction

   task automatic run(input logic [15:0] m, input logic [9:0] l, input int maxc, input int mode);
      logic         pv [2];
      logic [127:0] pd [2];
      logic [3:0]   pb [2];
      logic [8:0]   pa [2];
      logic         pl [2];
      logic         pr;
      int           out;
      for (int d = 0; d < 2; d++) begin
         nw[d] = 0; nlast[d] = 0; first_enb[d] = -1; last_enb[d] = -1; enb_cnt[d] = 0;
         first_vld[d] = -1; last_vld[d] = -1; vld_cnt[d] = 0; done_t[d] = -1; busy_low_t[d] = -1;
         hold_err[d] = 0; max_out[d] = 0; onehot_err[d] = 0; accepted[d] = 0; pv[d] = 1'b0;
         pd[d] = '0; pb[d] = '0; pa[d] = '0; pl[d] = 1'b0;
         for (int k = 0; k < 256; k++) wl[d][k] = 1'b0;
      end
      pr = 1'b1;
      @(negedge clk);
      mask = m; len = l; start = 1'b1; rdy = 1'b1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mode == 1) rdy = (i >= 20 && i < 36) ? 1'b0 : 1'($urandom_range(0, 1));
         else           rdy = 1'b1;
         #1;
         for (int d = 0; d < 2; d++) begin
            if (enb[d] != 16'h0) begin
               enb_cnt[d]++;
               if (first_enb[d] < 0) first_enb[d] = i;
               last_enb[d] = i;
               if (!$onehot(enb[d])) onehot_err[d]++;
            end
            out = enb_cnt[d] - accepted[d];
            if (out > max_out[d]) max_out[d] = out;
            if (pv[d] && !pr)
               if (!vld[d] || dat[d] !== pd[d] || bnk[d] !== pb[d] || adr[d] !== pa[d] || lst[d] !== pl[d])
                  hold_err[d]++;
            if (vld[d]) begin
               vld_cnt[d]++;
               if (first_vld[d] < 0) first_vld[d] = i;
               last_vld[d] = i;
               if (rdy && nw[d] < 256) begin
                  wb[d][nw[d]] = bnk[d]; wa[d][nw[d]] = adr[d]; wd[d][nw[d]] = dat[d]; wl[d][nw[d]] = lst[d];
                  if (lst[d]) nlast[d]++;
                  nw[d]++;
               end
               if (rdy) accepted[d]++;
            end
            if (done[d] && done_t[d] < 0) done_t[d] = i;
            if (!busy[d] && busy_low_t[d] < 0) busy_low_t[d] = i;
            pv[d] = vld[d]; pd[d] = dat[d]; pb[d] = bnk[d]; pa[d] = adr[d]; pl[d] = lst[d];
         end
         pr = rdy;
         if (done_t[0] >= 0 && done_t[1] >= 0 && i >= done_t[0] + 2 && i >= done_t[1] + 2) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({enb[d], addrb[d], vld[d], dat[d], bnk[d], adr[d], lst[d], busy[d], done[d]} !== '0) begin
            fails++;
            $display("FAIL reset_outputs dut%0d: got enb=%h addrb=%h vld=%b data=%h busy=%b done=%b, expected all zero",
                     d, enb[d], addrb[d], vld[d], dat[d], busy[d], done[d]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_full_bank();
      for (int a = 0; a < 128; a++) mem[1][a] = 128'h41312111;
      run(16'h0002, 10'd128, 400, 0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (nw[d] !== 128) begin fails++; $display("FAIL full_count dut%0d: got %0d, expected 128", d, nw[d]); end
         for (int k = 0; k < nw[d] && k < 128; k++) begin
            tests++;
            if (wd[d][k] !== 128'h41312111 || wb[d][k] !== 4'd1 || wa[d][k] !== 9'(k)) begin
               fails++;
               $display("FAIL full_word dut%0d k=%0d: got bank=%0d addr=%0d data=%h, expected bank=1 addr=%0d data=41312111",
                        d, k, wb[d][k], wa[d][k], wd[d][k], k);
            end
         end
         tests++;
         if (nlast[d] !== 1 || wl[d][127] !== 1'b1) begin
            fails++; $display("FAIL full_last dut%0d: got %0d last flags (addr127=%b), expected 1 on addr 127", d, nlast[d], wl[d][127]);
         end
         tests++;
         if (first_enb[d] !== 1) begin fails++; $display("FAIL full_first_enb dut%0d: got %0d, expected 1", d, first_enb[d]); end
         tests++;
         if (first_vld[d] !== 3 + d) begin fails++; $display("FAIL full_first_vld dut%0d: got %0d, expected %0d", d, first_vld[d], 3 + d); end
         tests++;
         if (done_t[d] !== 131 + d) begin fails++; $display("FAIL full_done dut%0d: got %0d, expected %0d", d, done_t[d], 131 + d); end
         tests++;
         if (busy_low_t[d] !== 132 + d) begin fails++; $display("FAIL full_busy_fall dut%0d: got %0d, expected %0d", d, busy_low_t[d], 132 + d); end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 16; n++)
         for (int a = 0; a < 4; a++) mem[n][a] = pat(n);
      run(16'hFFFF, 10'd4, 300, 0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (nw[d] !== 64) begin fails++; $display("FAIL all_count dut%0d: got %0d, expected 64", d, nw[d]); end
         for (int k = 0; k < nw[d] && k < 64; k++) begin
            tests++;
            if (wb[d][k] !== 4'(k / 4) || wa[d][k] !== 9'(k % 4) || wd[d][k] !== pat(k / 4)) begin
               fails++;
               $display("FAIL all_word dut%0d k=%0d: got bank=%0d addr=%0d data=%h, expected bank=%0d addr=%0d data=%h",
                        d, k, wb[d][k], wa[d][k], wd[d][k], k / 4, k % 4, pat(k / 4));
            end
         end
         tests++;
         if (nlast[d] !== 1 || wl[d][63] !== 1'b1) begin
            fails++; $display("FAIL all_last dut%0d: got %0d last flags (final=%b), expected 1 on bank15 addr3", d, nlast[d], wl[d][63]);
         end
         tests++;
         if (vld_cnt[d] !== 64 || last_vld[d] - first_vld[d] + 1 !== 64) begin
            fails++; $display("FAIL all_gapless dut%0d: got %0d valid over span %0d, expected 64 over 64",
                              d, vld_cnt[d], last_vld[d] - first_vld[d] + 1);
         end
         tests++;
         if (done_t[d] !== 67 + d) begin fails++; $display("FAIL all_done dut%0d: got %0d, expected %0d", d, done_t[d], 67 + d); end
      end
   endtask

   task automatic test_sparse();
      logic [3:0] eb [4];
      logic [8:0] ea [4];
      eb[0] = 4'd0;  eb[1] = 4'd0;  eb[2] = 4'd15; eb[3] = 4'd15;
      ea[0] = 9'd0;  ea[1] = 9'd1;  ea[2] = 9'd0;  ea[3] = 9'd1;
      run(16'h8001, 10'd2, 100, 0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (nw[d] !== 4) begin fails++; $display("FAIL sparse_count dut%0d: got %0d, expected 4", d, nw[d]); end
         for (int k = 0; k < nw[d] && k < 4; k++) begin
            tests++;
            if (wb[d][k] !== eb[k] || wa[d][k] !== ea[k] || wd[d][k] !== pat(int'(eb[k])) || wl[d][k] !== (k == 3)) begin
               fails++;
               $display("FAIL sparse_word dut%0d k=%0d: got (%0d,%0d) last=%b, expected (%0d,%0d) last=%b",
                        d, k, wb[d][k], wa[d][k], wl[d][k], eb[k], ea[k], k == 3);
            end
         end
         tests++;
         if (enb_cnt[d] !== 4 || last_enb[d] - first_enb[d] !== 3) begin
            fails++; $display("FAIL sparse_issue_bubble dut%0d: got %0d reads over span %0d, expected 4 over 3",
                              d, enb_cnt[d], last_enb[d] - first_enb[d]);
         end
         tests++;
         if (last_vld[d] - first_vld[d] + 1 !== 4) begin
            fails++; $display("FAIL sparse_stream_bubble dut%0d: got span %0d, expected 4", d, last_vld[d] - first_vld[d] + 1);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int a = 0; a < 48; a++) mem[2][a] = {16'hB2B2, 96'h0, 16'(a)};
      run(16'h0004, 10'd48, 800, 1);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (nw[d] !== 48) begin fails++; $display("FAIL bp_count dut%0d: got %0d, expected 48", d, nw[d]); end
         for (int k = 0; k < nw[d] && k < 48; k++) begin
            tests++;
            if (wb[d][k] !== 4'd2 || wa[d][k] !== 9'(k) || wd[d][k] !== mem[2][k]) begin
               fails++;
               $display("FAIL bp_word dut%0d k=%0d: got bank=%0d addr=%0d data=%h, expected bank=2 addr=%0d data=%h",
                        d, k, wb[d][k], wa[d][k], wd[d][k], k, mem[2][k]);
            end
         end
         tests++;
         if (hold_err[d] !== 0) begin fails++; $display("FAIL bp_hold dut%0d: got %0d unstable stall cycles, expected 0", d, hold_err[d]); end
         tests++;
         if (max_out[d] !== 4) begin fails++; $display("FAIL bp_outstanding dut%0d: got max %0d, expected 4", d, max_out[d]); end
         tests++;
         if (onehot_err[d] !== 0) begin fails++; $display("FAIL bp_onehot dut%0d: got %0d bad enables, expected 0", d, onehot_err[d]); end
         tests++;
         if (nlast[d] !== 1 || wl[d][47] !== 1'b1) begin
            fails++; $display("FAIL bp_last dut%0d: got %0d last flags (addr47=%b), expected 1 on addr 47", d, nlast[d], wl[d][47]);
         end
         tests++;
         if (done_t[d] < 0) begin fails++; $display("FAIL bp_done dut%0d: got no oDone, expected a pulse", d); end
      end
   endtask

   task automatic test_empty();
      for (int c = 0; c < 2; c++) begin
         if (c == 0) run(16'h0000, 10'd5, 20, 0);
         else        run(16'hFFFF, 10'd0, 20, 0);
         for (int d = 0; d < 2; d++) begin
            tests++;
            if (done_t[d] !== 1) begin fails++; $display("FAIL empty%0d_done dut%0d: got %0d, expected 1", c, d, done_t[d]); end
            tests++;
            if (enb_cnt[d] !== 0 || vld_cnt[d] !== 0) begin
               fails++; $display("FAIL empty%0d_activity dut%0d: got %0d reads %0d valid, expected 0 0", c, d, enb_cnt[d], vld_cnt[d]);
            end
            tests++;
            if (busy_low_t[d] !== 2) begin fails++; $display("FAIL empty%0d_busy dut%0d: got %0d, expected 2", c, d, busy_low_t[d]); end
         end
      end
   endtask

   task automatic test_reset_midrun();
      int bad [2];
      run(16'hFFFF, 10'd128, 10, 0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({enb[d], addrb[d], vld[d], dat[d], bnk[d], adr[d], lst[d], busy[d], done[d]} !== '0) begin
            fails++;
            $display("FAIL midrun_reset dut%0d: got enb=%h addrb=%h vld=%b data=%h busy=%b, expected all zero",
                     d, enb[d], addrb[d], vld[d], dat[d], busy[d]);
         end
      end
      rst = 1'b0;
      bad[0] = 0; bad[1] = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         for (int d = 0; d < 2; d++) if (vld[d] !== 1'b0 || enb[d] !== 16'h0) bad[d]++;
      end
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (bad[d] !== 0) begin fails++; $display("FAIL midrun_stale dut%0d: got %0d active cycles, expected 0", d, bad[d]); end
      end
      run(16'h0002, 10'd3, 100, 0);
      for (int d = 0; d < 2; d++) begin
         tests++;
         if (nw[d] !== 3) begin fails++; $display("FAIL rerun_count dut%0d: got %0d, expected 3", d, nw[d]); end
         for (int k = 0; k < nw[d] && k < 3; k++) begin
            tests++;
            if (wb[d][k] !== 4'd1 || wa[d][k] !== 9'(k) || wd[d][k] !== 128'h41312111) begin
               fails++;
               $display("FAIL rerun_word dut%0d k=%0d: got bank=%0d addr=%0d data=%h, expected bank=1 addr=%0d data=41312111",
                        d, k, wb[d][k], wa[d][k], wd[d][k], k);
            end
         end
         tests++;
         if (done_t[d] !== 6 + d) begin fails++; $display("FAIL rerun_done dut%0d: got %0d, expected %0d", d, done_t[d], 6 + d); end
      end
   endtask

   initial begin
      for (int b = 0; b < 16; b++)
         for (int a = 0; a < 512; a++) mem[b][a] = '0;
      test_reset();
      test_full_bank();
      test_back_to_back();
      test_sparse();
      test_backpressure();
      test_empty();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end
endmodule
